// File: rtl/serial_fa_adder.sv
// serial_fa_adder: bit-serial WIDTH-bit adder driving one fa_ha full-adder cell, LSB first.
//   clk, rst_n (async active-low); start/a/b/cin sampled when IDLE or DONE;
//   busy high during RUN, done one-cycle pulse, sum/cout registered result.
`timescale 1ns/1ps
module fa_ha (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_fa_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic [WIDTH:0] res_cat;
  logic [CW-1:0] cnt;
  logic carry, s, c, last, accept;
  fa_ha u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(s), .cout(c));
  assign last    = cnt == CW'(WIDTH - 1);
  assign accept  = start && state != RUN;
  // Concatenate then drop the LSB so the shift also elaborates for WIDTH=1.
  assign res_cat = {s, res_sh};
  assign res_nxt = res_cat[WIDTH:1];
  assign busy    = state == RUN;
  assign done    = state == DONE;
  always_comb begin
    state_nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      carry  <= c;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum  <= res_nxt;
        cout <= c;
      end
    end
  end
endmodule

// File: tb/tb_serial_fa_adder.sv
// tb_serial_fa_adder: directed self-checking bench for serial_fa_adder (WIDTH=8 and WIDTH=1 builds).
`timescale 1ns/1ps
module tb_serial_fa_adder;
  logic clk = 0, rst_n = 0;
  logic start = 0, cin = 0;
  logic [7:0] a = 0, b = 0;
  logic busy, done, cout;
  logic [7:0] sum;
  logic start1 = 0, a1 = 0, b1 = 0, cin1 = 0;
  logic busy1, done1, cout1;
  logic [0:0] sum1;
  int n_cmp = 0, n_err = 0;
  int nb, gap, npulse;
  logic [7:0] cap_sum;
  logic cap_cout;

  always #5 clk = ~clk;

  serial_fa_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  serial_fa_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic go(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1;
    @(negedge clk);
    start = 0;
    run_busy(nb);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    go(8'h5A, 8'h3C, 0);
    chk("t1_busy_cycles", nb, 8);
    chk("t1_done", done, 1);
    chk("t1_sum", sum, 8'h96);
    chk("t1_cout", cout, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    go(8'hFF, 8'h01, 0);
    chk("t2a_done", done, 1);
    chk("t2a_sum", sum, 8'h00);
    chk("t2a_cout", cout, 1);
    @(negedge clk);
    go(8'hFF, 8'hFF, 1);
    chk("t2b_sum", sum, 8'hFF);
    chk("t2b_cout", cout, 1);
    @(negedge clk);

    a = 8'h10; b = 8'h20; cin = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_busy_mid", busy, 1);
    chk("t3_sum_hold", sum, 8'hFF);
    start = 1; a = 8'hAA; b = 8'h55; cin = 1;
    @(negedge clk); start = 0;
    npulse = 0; cap_sum = 0; cap_cout = 1'bx;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        npulse++;
        cap_sum = sum;
        cap_cout = cout;
      end
      @(negedge clk);
    end
    chk("t3_pulses", npulse, 1);
    chk("t3_sum", cap_sum, 8'h30);
    chk("t3_cout", cap_cout, 0);
    chk("t3_idle", busy, 0);

    go(8'h10, 8'h20, 0);
    chk("t4_first_done", done, 1);
    chk("t4_first_sum", sum, 8'h30);
    a = 8'h01; b = 8'h02; cin = 0; start = 1;
    @(negedge clk);
    chk("t4_restart_busy", busy, 1);
    chk("t4_restart_nodone", done, 0);
    chk("t4_sum_held", sum, 8'h30);
    start = 0;
    run_busy(nb);
    gap = nb + 1;
    chk("t4_gap_edges", gap, 9);
    chk("t4_second_done", done, 1);
    chk("t4_second_sum", sum, 8'h03);
    chk("t4_second_cout", cout, 0);
    @(negedge clk);

    a = 8'h12; b = 8'h34; cin = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_sum", sum, 0);
    chk("t5_cout", cout, 0);
    @(negedge clk); rst_n = 1;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) npulse++;
      @(negedge clk);
    end
    chk("t5_no_activity", npulse, 0);
    go(8'h7F, 8'h01, 0);
    chk("t5_busy_cycles", nb, 8);
    chk("t5_sum", sum, 8'h80);
    chk("t5_cout_new", cout, 0);
    @(negedge clk);

    a1 = 1; b1 = 1; cin1 = 1; start1 = 1;
    @(negedge clk); start1 = 0;
    chk("t6_busy", busy1, 1);
    chk("t6_nodone", done1, 0);
    @(negedge clk);
    chk("t6_busy_off", busy1, 0);
    chk("t6_done", done1, 1);
    chk("t6_sum", sum1, 1);
    chk("t6_cout", cout1, 1);
    @(negedge clk);
    chk("t6_done_pulse", done1, 0);
    a1 = 1; b1 = 0; cin1 = 0; start1 = 1;
    @(negedge clk); start1 = 0;
    @(negedge clk);
    chk("t6b_done", done1, 1);
    chk("t6b_sum", sum1, 1);
    chk("t6b_cout", cout1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
